// File: rtl/mux_pipe_reg_if.sv
// Handshake/bus bundle for mux_pipe_reg: flattened data inputs, select,
// valid, pipeline control (stall/flush) and the registered results.
// master = upstream producer/controller side, slave = the mux stage itself.
interface mux_pipe_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic [SEL_W-1:0]        sel_q;
    logic                    sel_err;

    modport master (
        output in_bus,
        output sel,
        output in_valid,
        output stall,
        output flush,
        input  out,
        input  out_valid,
        input  sel_q,
        input  sel_err
    );

    modport slave (
        input  in_bus,
        input  sel,
        input  in_valid,
        input  stall,
        input  flush,
        output out,
        output out_valid,
        output sel_q,
        output sel_err
    );
endinterface

// File: rtl/mux_pipe_reg.sv
// Registered NUM_IN:1 mux stage with valid, stall (hold) and flush (bubble); optional sticky bad-select flag under MUX_PIPE_REG_SEL_CHECK_EN.
// Latency: fixed 1 cycle from sel/in_bus/in_valid to out/out_valid/sel_q; no combinational input-to-output path.
// Backpressure: stall holds the stage contents; flush overrides stall and loads RESET_VAL with out_valid=0.
module mux_pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter int               SEL_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    mux_pipe_reg_if.slave   bus
);

    // Reject configurations the select cannot address or that fall outside the supported fan-in.
    if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
        $error("mux_pipe_reg: illegal NUM_IN/SEL_W combination");
    end

    logic [WIDTH-1:0] mux_dat;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] sel_r;
    logic             load;

    // A load happens only when the stage is neither being killed nor held.
    assign load = !bus.flush && !bus.stall;

    // Select input[sel]; a select with no matching input falls through to RESET_VAL.
    always_comb begin
        mux_dat = RESET_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                mux_dat = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Pipeline register: flush inserts a bubble, stall holds, otherwise capture
    // data regardless of in_valid (downstream qualifies with out_valid).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r       <= RESET_VAL;
            out_valid_r <= 1'b0;
            sel_r       <= '0;
        end else if (bus.flush) begin
            out_r       <= RESET_VAL;
            out_valid_r <= 1'b0;
            sel_r       <= '0;
        end else if (!bus.stall) begin
            out_r       <= mux_dat;
            out_valid_r <= bus.in_valid;
            sel_r       <= bus.sel;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sel_q     = sel_r;

`ifdef MUX_PIPE_REG_SEL_CHECK_EN
    // NUM_IN widened by one bit so the unsigned compare is exact even when
    // NUM_IN == 2^SEL_W (every select then counts as in range).
    localparam logic [SEL_W:0] NUM_IN_CMP = (SEL_W+1)'(NUM_IN);

    logic sel_in_range;
    logic sel_err_r;

    assign sel_in_range = ({1'b0, bus.sel} < NUM_IN_CMP);

    // Sticky flag: only a real (valid, loading) out-of-range select counts;
    // flush and stall leave it untouched, only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_r <= 1'b0;
        end else if (load && bus.in_valid && !sel_in_range) begin
            sel_err_r <= 1'b1;
        end
    end

    assign bus.sel_err = sel_err_r;
`else
    assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_reg.sv
module tb_mux_pipe_reg;

`ifdef MUX_PIPE_REG_SEL_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic clk;
    logic reset;

    // Instance A: NUM_IN == 2^SEL_W (no select is ever out of range).
    // Instance B: NUM_IN = 3, so sel = 3 is out of range.
    mux_pipe_reg_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus_a ();
    mux_pipe_reg_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus_b ();

    mux_pipe_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .RESET_VAL(32'h0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mux_pipe_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .RESET_VAL(32'h0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] din [4];

    // Reference model state, index 0 = instance A (4 inputs), 1 = instance B (3 inputs)
    logic [31:0] m_out [2];
    logic        m_vld [2];
    logic [1:0]  m_sel [2];
    logic        m_err [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 32'h0;
            m_vld[i] = 1'b0;
            m_sel[i] = 2'd0;
            m_err[i] = 1'b0;
        end
    endtask

    // Present one set of inputs, clock once, advance the model, settle 1 time unit.
    task automatic drive(input logic [1:0] s, input logic v, input logic st, input logic fl);
        bus_a.in_bus   = {din[3], din[2], din[1], din[0]};
        bus_b.in_bus   = {din[2], din[1], din[0]};
        bus_a.sel      = s;
        bus_b.sel      = s;
        bus_a.in_valid = v;
        bus_b.in_valid = v;
        bus_a.stall    = st;
        bus_b.stall    = st;
        bus_a.flush    = fl;
        bus_b.flush    = fl;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int n;
            n = (i == 0) ? 4 : 3;
            if (fl) begin
                m_out[i] = 32'h0;
                m_vld[i] = 1'b0;
                m_sel[i] = 2'd0;
            end else if (!st) begin
                m_sel[i] = s;
                m_vld[i] = v;
                m_out[i] = (int'(s) < n) ? din[s] : 32'h0;
                if (CHECK && v && int'(s) >= n) m_err[i] = 1'b1;
            end
        end
        #1;
    endtask

    // Assert reset between edges, then release it at the following negedge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        checks++; if (bus_a.out !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=%h", bus_a.out, 32'h0); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", bus_a.out_valid); end
        checks++; if (bus_a.sel_q !== 2'd0) begin errors++; $display("FAIL reset_selq got=%0d exp=0", bus_a.sel_q); end
        checks++; if (bus_b.sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus_b.sel_err); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load();
        din[0] = 32'h11111111; din[1] = 32'h22222222;
        din[2] = 32'h33333333; din[3] = 32'h44444444;
        drive(2'd2, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_a.out !== 32'h33333333) begin errors++; $display("FAIL load_out got=%h exp=33333333", bus_a.out); end
        checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL load_vld got=%b exp=1", bus_a.out_valid); end
        checks++; if (bus_a.sel_q !== 2'd2) begin errors++; $display("FAIL load_selq got=%0d exp=2", bus_a.sel_q); end
        checks++; if (bus_b.out !== 32'h33333333) begin errors++; $display("FAIL load_out_b got=%h exp=33333333", bus_b.out); end
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 4; s++) begin
            logic [1:0] ss;
            logic [31:0] exp_a;
            ss = s[1:0];
            exp_a = 32'h11111111 * (s + 1);
            drive(ss, 1'b1, 1'b0, 1'b0);
            checks++; if (bus_a.out !== exp_a) begin errors++; $display("FAIL sweep_out sel=%0d got=%h exp=%h", s, bus_a.out, exp_a); end
            checks++; if (bus_a.sel_q !== ss) begin errors++; $display("FAIL sweep_selq got=%0d exp=%0d", bus_a.sel_q, ss); end
            checks++; if (bus_b.out !== m_out[1]) begin errors++; $display("FAIL sweep_out_b sel=%0d got=%h exp=%h", s, bus_b.out, m_out[1]); end
        end
    endtask

    task automatic test_stall_flush();
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_a.out !== 32'h22222222) begin errors++; $display("FAIL pre_stall_out got=%h exp=22222222", bus_a.out); end
        for (int k = 0; k < 3; k++) begin
            logic [1:0] sk;
            sk = 2'(k + 2);
            drive(sk, 1'b0, 1'b1, 1'b0);
            checks++; if (bus_a.out !== 32'h22222222) begin errors++; $display("FAIL stall_out k=%0d got=%h exp=22222222", k, bus_a.out); end
            checks++; if (bus_a.sel_q !== 2'd1 || bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold k=%0d selq=%0d vld=%b exp selq=1 vld=1", k, bus_a.sel_q, bus_a.out_valid); end
        end
        drive(2'd3, 1'b1, 1'b1, 1'b1);
        checks++; if (bus_a.out !== 32'h0) begin errors++; $display("FAIL flush_out got=%h exp=0", bus_a.out); end
        checks++; if (bus_a.out_valid !== 1'b0 || bus_a.sel_q !== 2'd0) begin errors++; $display("FAIL flush_vld vld=%b selq=%0d exp vld=0 selq=0", bus_a.out_valid, bus_a.sel_q); end
        // First load after the bubble takes the inputs on that edge
        drive(2'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_a.out !== 32'h11111111) begin errors++; $display("FAIL post_flush_out got=%h exp=11111111", bus_a.out); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        checks++; if (bus_b.sel_err !== 1'b0) begin errors++; $display("FAIL oor_reset_err got=%b exp=0", bus_b.sel_err); end
        drive(2'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_b.out !== 32'h0 || bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL oor_inval_out got=%h vld=%b exp 0/0", bus_b.out, bus_b.out_valid); end
        checks++; if (bus_b.sel_err !== 1'b0) begin errors++; $display("FAIL oor_inval_err got=%b exp=0", bus_b.sel_err); end
        drive(2'd3, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_b.out !== 32'h0 || bus_b.out_valid !== 1'b1) begin errors++; $display("FAIL oor_val_out got=%h vld=%b exp 0/1", bus_b.out, bus_b.out_valid); end
        checks++; if (bus_b.sel_err !== CHECK) begin errors++; $display("FAIL oor_val_err got=%b exp=%b", bus_b.sel_err, CHECK); end
        checks++; if (bus_a.out !== 32'h44444444 || bus_a.sel_err !== 1'b0) begin errors++; $display("FAIL full_range_a out=%h err=%b exp 44444444/0", bus_a.out, bus_a.sel_err); end
        drive(2'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_b.out !== 32'h11111111 || bus_b.sel_err !== CHECK) begin errors++; $display("FAIL oor_sticky_load out=%h err=%b exp 11111111/%b", bus_b.out, bus_b.sel_err, CHECK); end
        drive(2'd2, 1'b1, 1'b0, 1'b1);
        checks++; if (bus_b.sel_err !== CHECK || bus_b.out !== 32'h0) begin errors++; $display("FAIL oor_sticky_flush err=%b out=%h exp %b/0", bus_b.sel_err, bus_b.out, CHECK); end
        do_reset();
        checks++; if (bus_b.sel_err !== 1'b0) begin errors++; $display("FAIL oor_clear_err got=%b exp=0", bus_b.sel_err); end
        // Out-of-range select while stalled or flushed is not an error
        drive(2'd3, 1'b1, 1'b1, 1'b0);
        drive(2'd3, 1'b1, 1'b0, 1'b1);
        checks++; if (bus_b.sel_err !== 1'b0) begin errors++; $display("FAIL oor_stall_flush_err got=%b exp=0", bus_b.sel_err); end
    endtask

    task automatic test_async_reset();
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_vld got=%b exp=1", bus_a.out_valid); end
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        checks++; if (bus_a.out_valid !== 1'b0 || bus_a.out !== 32'h0) begin errors++; $display("FAIL arst_immediate vld=%b out=%h exp 0/0", bus_a.out_valid, bus_a.out); end
        checks++; if (bus_a.sel_q !== 2'd0 || bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL arst_selq selq=%0d vld_b=%b exp 0/0", bus_a.sel_q, bus_b.out_valid); end
        @(negedge clk);
        reset = 1'b0;
        drive(2'd2, 1'b1, 1'b0, 1'b0);
        checks++; if (bus_a.out !== 32'h33333333 || bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL arst_first_load out=%h vld=%b exp 33333333/1", bus_a.out, bus_a.out_valid); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            logic [1:0] s;
            logic v, st, fl;
            for (int i = 0; i < 4; i++) din[i] = $urandom;
            s  = 2'($urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            if (it == 150) do_reset();
            drive(s, v, st, fl);
            checks++;
            if ({bus_a.out, bus_a.out_valid, bus_a.sel_q, bus_a.sel_err} !== {m_out[0], m_vld[0], m_sel[0], m_err[0]}) begin
                errors++;
                $display("FAIL rand_a it=%0d got out=%h vld=%b selq=%0d err=%b exp out=%h vld=%b selq=%0d err=%b",
                         it, bus_a.out, bus_a.out_valid, bus_a.sel_q, bus_a.sel_err, m_out[0], m_vld[0], m_sel[0], m_err[0]);
            end
            checks++;
            if ({bus_b.out, bus_b.out_valid, bus_b.sel_q, bus_b.sel_err} !== {m_out[1], m_vld[1], m_sel[1], m_err[1]}) begin
                errors++;
                $display("FAIL rand_b it=%0d got out=%h vld=%b selq=%0d err=%b exp out=%h vld=%b selq=%0d err=%b",
                         it, bus_b.out, bus_b.out_valid, bus_b.sel_q, bus_b.sel_err, m_out[1], m_vld[1], m_sel[1], m_err[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 32'h0;
        bus_a.in_bus = '0; bus_b.in_bus = '0;
        bus_a.sel = '0; bus_b.sel = '0;
        bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
        bus_a.stall = 1'b0; bus_b.stall = 1'b0;
        bus_a.flush = 1'b0; bus_b.flush = 1'b0;
        model_clear();
        test_reset();
        test_load();
        test_sweep();
        test_stall_flush();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
